// File: rtl/befehls_dekoder_pipeline.sv
// rtl/befehls_dekoder_pipeline.sv - FIFO-buffered instruction decode stage with valid/ready output register
// Optional macro HANS_DEC_ILLEGAL_EN adds a registered out_illegal flag.
module befehls_dekoder_pipeline #(
    parameter int DEPTH      = 4,
    parameter int REG_IDX_W  = 6,
    parameter int IMM_W      = 26,
    parameter int IMM_SIGNED = 0
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic                         flush,
    input  logic [31:0]                  in_instr,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [REG_IDX_W-1:0]         out_rs1,
    output logic [REG_IDX_W-1:0]         out_rs2,
    output logic [REG_IDX_W-1:0]         out_rd,
    output logic [IMM_W-1:0]             out_imm,
    output logic [5:0]                   out_funct,
    output logic [9:0]                   out_flags,
`ifdef HANS_DEC_ILLEGAL_EN
    output logic                         out_illegal,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   fill_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [31:0]          r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    logic                 w_push;
    logic                 w_pop;
    logic [31:0]          w_head;
    logic [5:0]           w_op;
    logic [1:0]           w_f;
    logic                 w_bank;
    logic [REG_IDX_W-1:0] w_rs1;
    logic [REG_IDX_W-1:0] w_rs2;
    logic [REG_IDX_W-1:0] w_rd;
    logic [IMM_W-1:0]     w_imm;
    logic [5:0]           w_funct;
    logic [9:0]           w_flags;

    assign in_ready   = (r_count != FULL_CNT);
    assign w_push     = in_valid && in_ready;
    assign w_pop      = (r_count != '0) && (!out_valid || out_ready);
    assign fill_level = r_count;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_op       = w_head[31:26];
    assign w_f        = w_head[5:4];

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= in_instr;
        end
    end

    always_comb begin
        w_bank  = 1'b0;
        w_rs1   = '0;
        w_rs2   = '0;
        w_rd    = '0;
        w_imm   = '0;
        w_funct = '0;
        w_flags = '0;
        case (w_op[5:4])
            2'b00: begin
                w_bank     = (w_f == 2'b10);
                w_rs1      = REG_IDX_W'({w_bank, w_head[15:11]});
                w_rs2      = REG_IDX_W'({w_bank, w_head[20:16]});
                w_rd       = REG_IDX_W'({w_bank, w_head[25:21]});
                w_funct    = w_head[5:0];
                w_flags[5] = w_bank;
            end
            2'b01: begin
                w_imm      = IMM_W'(w_head[25:0]);
                w_flags[1] = 1'b1;
            end
            default: begin
                w_rs1      = REG_IDX_W'(w_head[20:16]);
                w_rd       = REG_IDX_W'(w_head[25:21]);
                w_imm      = {{(IMM_W-16){(IMM_SIGNED != 0) && w_head[15]}}, w_head[15:0]};
                w_flags[0] = 1'b1;
                if (w_op == 6'b101100) begin
                    w_rs2 = REG_IDX_W'(w_head[25:21]);
                end
            end
        endcase
        w_flags[2] = (w_op == 6'b101111);
        w_flags[3] = (w_op == 6'b101111) || (w_op == 6'b010000) || (w_op == 6'b101110);
        w_flags[4] = (w_op == 6'b101101);
        w_flags[6] = (w_op[5:1] == 5'b10101);
        w_flags[7] = (w_op == 6'b101100);
        w_flags[8] = (w_op == 6'b101101) || (w_op == 6'b101111) || (w_op == 6'b010000);
        w_flags[9] = (w_op == 6'b101110);
    end

`ifdef HANS_DEC_ILLEGAL_EN
    logic w_illegal;
    assign w_illegal = ((w_op[5:4] == 2'b01) && (w_op != 6'b010000)) ||
                       ((w_op[5:4] == 2'b00) && (w_f == 2'b11));
`endif

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            out_valid   <= 1'b0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_imm     <= '0;
            out_funct   <= '0;
            out_flags   <= '0;
`ifdef HANS_DEC_ILLEGAL_EN
            out_illegal <= 1'b0;
`endif
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            out_valid   <= 1'b0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_imm     <= '0;
            out_funct   <= '0;
            out_flags   <= '0;
`ifdef HANS_DEC_ILLEGAL_EN
            out_illegal <= 1'b0;
`endif
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A stalled bundle is held untouched until the consumer takes it.
            if (w_pop) begin
                out_valid   <= 1'b1;
                out_rs1     <= w_rs1;
                out_rs2     <= w_rs2;
                out_rd      <= w_rd;
                out_imm     <= w_imm;
                out_funct   <= w_funct;
                out_flags   <= w_flags;
`ifdef HANS_DEC_ILLEGAL_EN
                out_illegal <= w_illegal;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_befehls_dekoder_pipeline.sv
// tb/tb_befehls_dekoder_pipeline.sv - self-checking bench for befehls_dekoder_pipeline (zero- and sign-extending instances)
module tb_befehls_dekoder_pipeline;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] in_instr = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, s_in_ready, s_out_valid;
    logic [5:0]  out_rs1, out_rs2, out_rd, s_rs1, s_rs2, s_rd;
    logic [25:0] out_imm, s_imm;
    logic [5:0]  out_funct, s_funct;
    logic [9:0]  out_flags, s_flags;
    logic [2:0]  fill_level, s_fill;
`ifdef HANS_DEC_ILLEGAL_EN
    logic        out_illegal, s_illegal;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    befehls_dekoder_pipeline #(.DEPTH(DEPTH), .REG_IDX_W(6), .IMM_W(26), .IMM_SIGNED(0)) u_dut (
        .clk(clk), .Reset(Reset), .flush(flush), .in_instr(in_instr), .in_valid(in_valid),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_funct(out_funct), .out_flags(out_flags),
`ifdef HANS_DEC_ILLEGAL_EN
        .out_illegal(out_illegal),
`endif
        .fill_level(fill_level)
    );

    befehls_dekoder_pipeline #(.DEPTH(DEPTH), .REG_IDX_W(6), .IMM_W(26), .IMM_SIGNED(1)) u_dut_s (
        .clk(clk), .Reset(Reset), .flush(flush), .in_instr(in_instr), .in_valid(in_valid),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_rs1(s_rs1), .out_rs2(s_rs2), .out_rd(s_rd), .out_imm(s_imm),
        .out_funct(s_funct), .out_flags(s_flags),
`ifdef HANS_DEC_ILLEGAL_EN
        .out_illegal(s_illegal),
`endif
        .fill_level(s_fill)
    );

    typedef struct {
        logic [5:0]  rs1, rs2, rd;
        logic [25:0] imm_u, imm_s;
        logic [5:0]  funct;
        logic [9:0]  flags;
        logic        ill;
    } bundle_t;

    function automatic bundle_t model_decode(input logic [31:0] w);
        bundle_t b;
        int op, bankv;
        op = int'(w[31:26]);
        b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.imm_u = 0; b.imm_s = 0;
        b.funct = 0; b.flags = 0; b.ill = 0;
        if (op < 16) begin
            bankv = (w[5:4] == 2'b10) ? 32 : 0;
            b.rs1 = 6'(bankv + int'(w[15:11]));
            b.rs2 = 6'(bankv + int'(w[20:16]));
            b.rd  = 6'(bankv + int'(w[25:21]));
            b.funct = w[5:0];
            b.flags[5] = (bankv != 0);
            b.ill = (w[5:4] == 2'b11);
        end else if (op < 32) begin
            b.imm_u = w[25:0];
            b.imm_s = w[25:0];
            b.flags[1] = 1'b1;
            b.ill = (op != 16);
        end else begin
            b.rs1 = 6'(w[20:16]);
            b.rd  = 6'(w[25:21]);
            if (op == 44) b.rs2 = 6'(w[25:21]);
            b.imm_u = 26'(w[15:0]);
            b.imm_s = w[15] ? 26'(w[15:0]) + 26'h3FF0000 : 26'(w[15:0]);
            b.flags[0] = 1'b1;
        end
        b.flags[2] = (op == 47);
        b.flags[3] = (op == 47) || (op == 16) || (op == 46);
        b.flags[4] = (op == 45);
        b.flags[6] = (op == 42) || (op == 43);
        b.flags[7] = (op == 44);
        b.flags[8] = (op == 45) || (op == 47) || (op == 16);
        b.flags[9] = (op == 46);
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of raw words plus one presented bundle.
    logic [31:0] mq[$];
    logic        m_valid = 1'b0;
    bundle_t     m_out;

    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            mq.delete();
            m_valid = 1'b0;
        end else begin
            bit do_push, do_pop;
            do_push = in_valid && (mq.size() < DEPTH);
            do_pop  = (mq.size() > 0) && (!m_valid || out_ready);
            if (flush) begin
                mq.delete();
                m_valid = 1'b0;
            end else begin
                if (do_pop) begin
                    m_out = model_decode(mq.pop_front());
                    m_valid = 1'b1;
                end else if (m_valid && out_ready) begin
                    m_valid = 1'b0;
                end
                if (do_push) mq.push_back(in_instr);
            end
        end
    end

    always @(negedge clk) begin
        if (!Reset) begin
            check("out_valid", out_valid, m_valid);
            check("s_out_valid", s_out_valid, m_valid);
            check("fill_level", fill_level, mq.size());
            check("s_fill_level", s_fill, mq.size());
            check("in_ready", in_ready, mq.size() < DEPTH);
            if (m_valid) begin
                check("rs1", out_rs1, m_out.rs1);
                check("rs2", out_rs2, m_out.rs2);
                check("rd", out_rd, m_out.rd);
                check("imm_zext", out_imm, m_out.imm_u);
                check("imm_sext", s_imm, m_out.imm_s);
                check("funct", out_funct, m_out.funct);
                check("flags", out_flags, m_out.flags);
                check("s_rs2", s_rs2, m_out.rs2);
`ifdef HANS_DEC_ILLEGAL_EN
                check("illegal", out_illegal, m_out.ill);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push1(input logic [31:0] w);
        in_instr = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    logic [31:0] vecs [10] = '{32'hA8A10004, 32'hAC000123, 32'hBC200010, 32'hB400FFFF,
                               32'hB8E3FFFE, 32'hC0000001, 32'h00001030, 32'h40000000,
                               32'h44000000, 32'h00A31010};

    initial begin
        bundle_t pin;
        logic [5:0] got[$];
        bit drained;

        pin = model_decode(32'hBC200010);
        check("pin_jal_flags", pin.flags, 10'h10D);
        pin = model_decode(32'hB0228000);
        check("pin_store_imm_s", pin.imm_s, 26'h3FF8000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_fill", fill_level, 0);
        check("rst_rd", out_rd, 0);
        check("rst_imm", s_imm, 0);
        check("rst_flags", out_flags, 0);
        @(posedge clk); #1;
        Reset = 1'b0;
        step();

        // R-type float bank, two-edge latency
        in_instr = 32'h00A31020; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("lat_first_edge", out_valid, 0);
        step();
        check("r_valid", out_valid, 1);
        check("r_rs1", out_rs1, 6'h22);
        check("r_rs2", out_rs2, 6'h23);
        check("r_rd", out_rd, 6'h25);
        check("r_float", out_flags[5], 1);
        check("r_funct", out_funct, 6'h20);
        idle(2);

        // Store immediate, both extension modes
        push1(32'hB0228000);
        step();
        check("st_flags", out_flags, 10'h081);
        check("st_rs1", out_rs1, 6'd2);
        check("st_rs2", out_rs2, 6'd1);
        check("st_imm_z", out_imm, 26'h0008000);
        check("st_imm_s", s_imm, 26'h3FF8000);
        idle(2);

        // Fill to full with a stalled consumer, then drain in order
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            in_instr = 32'((i + 1) << 21);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("full_fill", fill_level, DEPTH);
        check("full_in_ready", in_ready, 0);
        check("full_held_rd", out_rd, 6'd1);
        out_ready = 1'b1;
        drained = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) got.push_back(out_rd);
            if (!out_valid && fill_level == 0) begin
                drained = 1'b1;
                break;
            end
        end
        check("drain_done", drained, 1);
        check("drain_count", got.size(), DEPTH + 1);
        for (int i = 0; i < got.size() && i < DEPTH + 1; i++) check("drain_order", got[i], i + 1);
        step();

        // Simultaneous push/pop at fill_level 2, pointers wrapping
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_instr = 32'((i + 7) << 21); in_valid = 1'b1; step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_instr = 32'((i + 10) << 21) | 32'h20;
            in_valid = 1'b1;
            step();
            check("pp_fill", fill_level, 2);
        end
        idle(5);

        // Flush with a concurrent push
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_instr = 32'hA8000000 | i; in_valid = 1'b1; step();
        end
        check("pre_flush_fill", fill_level, 3);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00A31020;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_fill", fill_level, 0);
        check("flush_valid", out_valid, 0);
        out_ready = 1'b1;
        idle(3);
        check("flush_lost_valid", out_valid, 0);
        check("flush_lost_fill", fill_level, 0);

        // Directed decode table streamed through with the consumer ready
        for (int i = 0; i < 10; i++) begin
            in_instr = vecs[i]; in_valid = 1'b1; step();
        end
        idle(4);

`ifdef HANS_DEC_ILLEGAL_EN
        push1(32'h44000000);
        step();
        check("ill_set", out_illegal, 1);
        check("ill_flags", out_flags, 10'h002);
        idle(1);
        push1(32'h40000000);
        step();
        check("ill_clear", out_illegal, 0);
        check("ill_jflags", out_flags, 10'h10A);
        idle(2);
`endif

        // Asynchronous reset in the middle of traffic
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_instr = 32'hBC200010; in_valid = 1'b1; step();
        end
        in_valid = 1'b0;
        #3 Reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_fill", fill_level, 0);
        check("mid_rst_flags", out_flags, 0);
        check("mid_rst_imm", s_imm, 0);
        @(posedge clk); #1;
        Reset = 1'b0;
        out_ready = 1'b1;
        idle(3);
        check("post_rst_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
